exec_arbiter: RTL and testbench

EXEC_ARBITER -- requirements
Module: exec_arbiter

---
 rtl/exec_arbiter.sv | 142 ++++++++++++++
 tb/tb_exec_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_arbiter.sv
// Two-requester arbiter in front of a shared combinational execution unit.
// One operation in flight: grant in IDLE, one EXEC cycle to capture results, hold in RESP.
module exec_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,

  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [5:0]              req0_ALU_operation,
  input  logic [ADDRESS_BITS-1:0] req0_PC,
  input  logic [1:0]              req0_operand_A_sel,
  input  logic                    req0_operand_B_sel,
  input  logic                    req0_branch_op,
  input  logic [DATA_WIDTH-1:0]   req0_rs1_data,
  input  logic [DATA_WIDTH-1:0]   req0_rs2_data,
  input  logic [DATA_WIDTH-1:0]   req0_extend,

  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [5:0]              req1_ALU_operation,
  input  logic [ADDRESS_BITS-1:0] req1_PC,
  input  logic [1:0]              req1_operand_A_sel,
  input  logic                    req1_operand_B_sel,
  input  logic                    req1_branch_op,
  input  logic [DATA_WIDTH-1:0]   req1_rs1_data,
  input  logic [DATA_WIDTH-1:0]   req1_rs2_data,
  input  logic [DATA_WIDTH-1:0]   req1_extend,

  output logic [5:0]              eu_ALU_operation,
  output logic [ADDRESS_BITS-1:0] eu_PC,
  output logic [1:0]              eu_operand_A_sel,
  output logic                    eu_operand_B_sel,
  output logic                    eu_branch_op,
  output logic [DATA_WIDTH-1:0]   eu_rs1_data,
  output logic [DATA_WIDTH-1:0]   eu_rs2_data,
  output logic [DATA_WIDTH-1:0]   eu_extend,
  input  logic                    eu_branch,
  input  logic [DATA_WIDTH-1:0]   eu_ALU_result,
  input  logic [ADDRESS_BITS-1:0] eu_JALR_target,

  output logic                    rsp0_valid,
  input  logic                    rsp0_ready,
  output logic                    rsp1_valid,
  input  logic                    rsp1_ready,
  output logic [DATA_WIDTH-1:0]   rsp_ALU_result,
  output logic                    rsp_branch,
  output logic [ADDRESS_BITS-1:0] rsp_JALR_target
);

  // state | meaning
  // IDLE  | no operation in flight, grant is combinational
  // EXEC  | eu_* hold the granted operation, EU results captured this cycle
  // RESP  | rsp_* held for the granted requester until it takes them
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_next;
  logic   grant;
  logic   grant_id;
  logic   last_grant;
  logic   accept;
  logic   rsp_take;

  // Tie goes to the requester that did not win last time.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  assign accept     = (state == IDLE) && !reset && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;
  assign rsp0_valid = (state == RESP) && !grant_id;
  assign rsp1_valid = (state == RESP) && grant_id;
  assign rsp_take   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_take) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_id         <= 1'b0;
      last_grant       <= 1'b1;
      eu_ALU_operation <= '0;
      eu_PC            <= '0;
      eu_operand_A_sel <= '0;
      eu_operand_B_sel <= 1'b0;
      eu_branch_op     <= 1'b0;
      eu_rs1_data      <= '0;
      eu_rs2_data      <= '0;
      eu_extend        <= '0;
      rsp_ALU_result   <= '0;
      rsp_branch       <= 1'b0;
      rsp_JALR_target  <= '0;
    end else begin
      if (accept) begin
        grant_id   <= grant;
        last_grant <= grant;
        if (grant) begin
          eu_ALU_operation <= req1_ALU_operation;
          eu_PC            <= req1_PC;
          eu_operand_A_sel <= req1_operand_A_sel;
          eu_operand_B_sel <= req1_operand_B_sel;
          eu_branch_op     <= req1_branch_op;
          eu_rs1_data      <= req1_rs1_data;
          eu_rs2_data      <= req1_rs2_data;
          eu_extend        <= req1_extend;
        end else begin
          eu_ALU_operation <= req0_ALU_operation;
          eu_PC            <= req0_PC;
          eu_operand_A_sel <= req0_operand_A_sel;
          eu_operand_B_sel <= req0_operand_B_sel;
          eu_branch_op     <= req0_branch_op;
          eu_rs1_data      <= req0_rs1_data;
          eu_rs2_data      <= req0_rs2_data;
          eu_extend        <= req0_extend;
        end
      end
      if (state == EXEC) begin
        rsp_ALU_result  <= eu_ALU_result;
        rsp_branch      <= eu_branch;
        rsp_JALR_target <= eu_JALR_target;
      end
    end
  end

endmodule

// File: tb/tb_exec_arbiter.sv
// Bench for exec_arbiter: directed vector table, hold/reset corner sequences,
// then randomized traffic against a transaction-level model with a stub execution unit.
module tb_exec_arbiter;
  localparam int DW = 32;
  localparam int AW = 20;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          rv[2], rdy[2], rspv[2], rspr[2];
  logic [5:0]    op[2];
  logic [AW-1:0] pc[2];
  logic [1:0]    asel[2];
  logic          bsel[2], brop[2];
  logic [DW-1:0] rs1[2], rs2[2], ext[2];

  logic [5:0]    eu_op;
  logic [AW-1:0] eu_pc;
  logic [1:0]    eu_asel;
  logic          eu_bsel, eu_brop, eu_branch;
  logic [DW-1:0] eu_rs1, eu_rs2, eu_ext, eu_res;
  logic [AW-1:0] eu_jalr;
  logic [DW-1:0] rsp_res;
  logic          rsp_br;
  logic [AW-1:0] rsp_jalr;

  exec_arbiter #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(rv[0]), .req0_ready(rdy[0]), .req0_ALU_operation(op[0]), .req0_PC(pc[0]),
    .req0_operand_A_sel(asel[0]), .req0_operand_B_sel(bsel[0]), .req0_branch_op(brop[0]),
    .req0_rs1_data(rs1[0]), .req0_rs2_data(rs2[0]), .req0_extend(ext[0]),
    .req1_valid(rv[1]), .req1_ready(rdy[1]), .req1_ALU_operation(op[1]), .req1_PC(pc[1]),
    .req1_operand_A_sel(asel[1]), .req1_operand_B_sel(bsel[1]), .req1_branch_op(brop[1]),
    .req1_rs1_data(rs1[1]), .req1_rs2_data(rs2[1]), .req1_extend(ext[1]),
    .eu_ALU_operation(eu_op), .eu_PC(eu_pc), .eu_operand_A_sel(eu_asel),
    .eu_operand_B_sel(eu_bsel), .eu_branch_op(eu_brop), .eu_rs1_data(eu_rs1),
    .eu_rs2_data(eu_rs2), .eu_extend(eu_ext), .eu_branch(eu_branch),
    .eu_ALU_result(eu_res), .eu_JALR_target(eu_jalr),
    .rsp0_valid(rspv[0]), .rsp0_ready(rspr[0]), .rsp1_valid(rspv[1]), .rsp1_ready(rspr[1]),
    .rsp_ALU_result(rsp_res), .rsp_branch(rsp_br), .rsp_JALR_target(rsp_jalr)
  );

  // Stub execution unit: A = PC when A_sel==1 else rs1; B = extend when B_sel else rs2.
  function automatic logic [DW-1:0] opa_f(input logic [1:0] as, input logic [AW-1:0] p, input logic [DW-1:0] a1);
    return (as == 2'd1) ? {{(DW-AW){1'b0}}, p} : a1;
  endfunction
  function automatic logic [DW-1:0] opb_f(input logic bs, input logic [DW-1:0] a2, input logic [DW-1:0] e);
    return bs ? e : a2;
  endfunction
  function automatic logic [DW-1:0] alu_f(input logic [5:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (o)
      6'd10:   return a & b;
      6'd12:   return a >> b[4:0];
      6'd14:   return a - b;
      default: return a + b;
    endcase
  endfunction
  function automatic logic [AW-1:0] jalr_f(input logic [DW-1:0] a1, input logic [DW-1:0] e);
    logic [DW-1:0] s;
    s = a1 + e;
    return s[AW-1:0];
  endfunction

  always_comb begin
    eu_res    = alu_f(eu_op, opa_f(eu_asel, eu_pc, eu_rs1), opb_f(eu_bsel, eu_rs2, eu_ext));
    eu_branch = eu_brop && (opa_f(eu_asel, eu_pc, eu_rs1) == opb_f(eu_bsel, eu_rs2, eu_ext));
    eu_jalr   = jalr_f(eu_rs1, eu_ext);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    for (int n = 0; n < 2; n++) begin
      rv[n] = 0; rspr[n] = 0; op[n] = '0; pc[n] = '0; asel[n] = '0; bsel[n] = 0;
      brop[n] = 0; rs1[n] = '0; rs2[n] = '0; ext[n] = '0;
    end
  endtask

  // Valids already driven: expect grant g this cycle, nothing in EXEC, result in RESP.
  task automatic txn(input string nm, input int g, input logic [DW-1:0] exp_res);
    @(negedge clock);
    chk({nm, " req0_ready"}, DW'(rdy[0]), DW'(g == 0));
    chk({nm, " req1_ready"}, DW'(rdy[1]), DW'(g == 1));
    tick();
    rv[0] = 0; rv[1] = 0;
    @(negedge clock);
    chk({nm, " exec rsp_valid"}, DW'({rspv[1], rspv[0]}), '0);
    tick();
    @(negedge clock);
    chk({nm, " rsp0_valid"}, DW'(rspv[0]), DW'(g == 0));
    chk({nm, " rsp1_valid"}, DW'(rspv[1]), DW'(g == 1));
    chk({nm, " rsp_ALU_result"}, rsp_res, exp_res);
    tick();
    rspr[g] = 1;
    @(negedge clock);
    tick();
    rspr[g] = 0;
  endtask

  typedef struct {
    string         name;
    logic          v0, v1, bs0, bs1;
    logic [5:0]    op0, op1;
    logic [DW-1:0] a0, b0, e0, a1, b1, e1;
    int            exp_g;
    logic [DW-1:0] exp_res;
  } vec_t;

  vec_t vecs[5];

  // Transaction-level reference state for the random phase.
  bit            inflight, exp_id, last_id;
  int            age;
  logic [DW-1:0] m_res;
  logic          m_br;
  logic [AW-1:0] m_jalr;

  initial begin
    vecs[0] = '{"single0", 1, 0, 0, 0, 6'd12, 6'd0, 15, 2, 0, 0, 0, 0, 0, 32'h00000003};
    vecs[1] = '{"single1", 0, 1, 0, 0, 6'd0, 6'd14, 0, 0, 0, 5, 7, 0, 1, 32'hfffffffe};
    vecs[2] = '{"both_a", 1, 1, 1, 0, 6'd10, 6'd12, 4, 0, 4, 15, 2, 0, 0, 32'h00000004};
    vecs[3] = '{"both_b", 1, 1, 1, 0, 6'd10, 6'd12, 4, 0, 4, 15, 2, 0, 1, 32'h00000003};
    vecs[4] = '{"both_c", 1, 1, 1, 0, 6'd10, 6'd12, 4, 0, 4, 15, 2, 0, 0, 32'h00000004};

    clear_inputs();
    reset = 1;
    rv[0] = 1; rv[1] = 1;
    #2;
    chk("reset ready", DW'({rdy[1], rdy[0]}), '0);
    chk("reset rsp_valid", DW'({rspv[1], rspv[0]}), '0);
    chk("reset eu_rs1", eu_rs1, '0);
    chk("reset eu_op", DW'(eu_op), '0);
    chk("reset rsp_result", rsp_res, '0);
    tick();
    tick();
    rv[0] = 0; rv[1] = 0;
    reset = 0;
    tick();

    for (int i = 0; i < 5; i++) begin
      op[0] = vecs[i].op0; rs1[0] = vecs[i].a0; rs2[0] = vecs[i].b0; ext[0] = vecs[i].e0; bsel[0] = vecs[i].bs0;
      op[1] = vecs[i].op1; rs1[1] = vecs[i].a1; rs2[1] = vecs[i].b1; ext[1] = vecs[i].e1; bsel[1] = vecs[i].bs1;
      rv[0] = vecs[i].v0; rv[1] = vecs[i].v1;
      txn(vecs[i].name, vecs[i].exp_g, vecs[i].exp_res);
    end

    // Response back-pressure with req1 waiting the whole time.
    clear_inputs();
    op[0] = 6'd12; rs1[0] = 15; rs2[0] = 2;
    op[1] = 6'd14; rs1[1] = 5; rs2[1] = 7;
    rv[0] = 1;
    @(negedge clock);
    chk("hold req0_ready", DW'(rdy[0]), 1);
    tick();
    rv[0] = 0; rv[1] = 1;
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("hold rsp0_valid", DW'(rspv[0]), 1);
      chk("hold rsp_result", rsp_res, 32'h00000003);
      chk("hold req1_ready", DW'(rdy[1]), 0);
      tick();
    end
    rspr[0] = 1;
    tick();
    rspr[0] = 0;
    txn("after_hold", 1, 32'hfffffffe);

    // Reset while a response is pending.
    clear_inputs();
    op[0] = 6'd12; rs1[0] = 15; rs2[0] = 2;
    rv[0] = 1;
    tick();
    rv[0] = 0;
    tick();
    @(negedge clock);
    chk("pre-reset rsp0_valid", DW'(rspv[0]), 1);
    #2;
    reset = 1;
    rv[0] = 1;
    #1;
    chk("midreset rsp0_valid", DW'(rspv[0]), 0);
    chk("midreset rsp_result", rsp_res, '0);
    chk("midreset eu_rs1", eu_rs1, '0);
    chk("midreset req0_ready", DW'(rdy[0]), 0);
    tick();
    rv[0] = 0;
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("post-reset rsp_valid", DW'({rspv[1], rspv[0]}), '0);
      tick();
    end
    rv[0] = 1;
    txn("post_reset", 0, 32'h00000003);

    // Random traffic against the transaction-level model.
    reset = 1;
    tick();
    reset = 0;
    inflight = 0; last_id = 1; age = 0;
    for (int c = 0; c < 600; c++) begin
      bit g;
      bit exp_r0, exp_r1, out_ok;
      for (int n = 0; n < 2; n++) begin
        rv[n]   = ($urandom_range(0, 2) != 0);
        rspr[n] = $urandom_range(0, 1);
        case ($urandom_range(0, 3))
          0: op[n] = 6'd10;
          1: op[n] = 6'd12;
          2: op[n] = 6'd14;
          default: op[n] = 6'd0;
        endcase
        pc[n]   = AW'($urandom);
        asel[n] = 2'($urandom_range(0, 3));
        bsel[n] = $urandom_range(0, 1);
        brop[n] = $urandom_range(0, 1);
        rs1[n]  = $urandom;
        rs2[n]  = ($urandom_range(0, 3) == 0) ? rs1[n] : $urandom;
        ext[n]  = ($urandom_range(0, 3) == 0) ? rs1[n] : $urandom;
      end
      @(negedge clock);
      g = (rv[0] && rv[1]) ? !last_id : (rv[1] && !rv[0]);
      exp_r0 = !inflight && (rv[0] || rv[1]) && !g;
      exp_r1 = !inflight && (rv[0] || rv[1]) && g;
      chk("rand req0_ready", DW'(rdy[0]), DW'(exp_r0));
      chk("rand req1_ready", DW'(rdy[1]), DW'(exp_r1));
      out_ok = inflight && (age >= 2);
      chk("rand rsp0_valid", DW'(rspv[0]), DW'(out_ok && !exp_id));
      chk("rand rsp1_valid", DW'(rspv[1]), DW'(out_ok && exp_id));
      if (out_ok) begin
        chk("rand rsp_result", rsp_res, m_res);
        chk("rand rsp_branch", DW'(rsp_br), DW'(m_br));
        chk("rand rsp_jalr", DW'(rsp_jalr), DW'(m_jalr));
      end
      if (!inflight && (rv[0] || rv[1])) begin
        logic [DW-1:0] a, b;
        inflight = 1; age = 1; exp_id = g; last_id = g;
        a = opa_f(asel[g], pc[g], rs1[g]);
        b = opb_f(bsel[g], rs2[g], ext[g]);
        m_res  = alu_f(op[g], a, b);
        m_br   = brop[g] && (a == b);
        m_jalr = jalr_f(rs1[g], ext[g]);
      end else if (inflight) begin
        if (out_ok && rspr[exp_id]) inflight = 0;
        else age++;
      end
      tick();
    end

    clear_inputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
